// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debouncer family.
// Latency: none (package only).
// Backpressure: none.
package key_pkg;

   // Level a key pin reads while it is held down.
   localparam logic KEY_ACTIVE = 1'b0;

   // Default timing at a 50 MHz system clock.
   localparam int unsigned CNT_20MS     = 999_999;
   localparam int unsigned LONG_1S      = 49_999_999;
   localparam int unsigned REPEAT_200MS = 9_999_999;

   // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, stability debounce, press/release/long/repeat pulses.
// Latency: flag and state update CNT_MAX+1 edges after the first sync flop captures a stable change.
// Backpressure: none; all flags are single-cycle pulses that are never held.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX    = CNT_20MS,
   parameter int unsigned LONG_MAX   = LONG_1S,
   parameter bit          REPEAT_EN  = 1'b0,
   parameter int unsigned REPEAT_MAX = REPEAT_200MS
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic state_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned CNT_W  = cnt_width(CNT_MAX);
   localparam int unsigned LONG_W = cnt_width(LONG_MAX);
   localparam int unsigned RPT_W  = cnt_width(REPEAT_MAX);

   localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX - 1);
   localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_MAX - 1);
   localparam logic [RPT_W-1:0]  RPT_TOP  = RPT_W'(REPEAT_MAX - 1);

   logic [1:0]        sync_q;
   logic              state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
   logic              long_done_q, long_done_d;
   logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
   logic              mismatch, long_hit;

   // Debounce: count consecutive mismatch cycles, accept the new level at the terminal count.
   always_comb begin
      mismatch  = (sync_q[1] != state_q);
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (mismatch) begin
         if (cnt_q == CNT_TOP) begin
            state_d   = sync_q[1];
            press_d   = (sync_q[1] == KEY_ACTIVE);
            release_d = (sync_q[1] != KEY_ACTIVE);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Long press and auto-repeat timing; a release on the same edge wins over a long pulse.
   always_comb begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
      rpt_cnt_d   = '0;
      long_hit    = 1'b0;
      if (state_q == KEY_ACTIVE) begin
         long_cnt_d  = long_cnt_q;
         long_done_d = long_done_q;
         rpt_cnt_d   = rpt_cnt_q;
         if (!long_done_q) begin
            if (long_cnt_q == LONG_TOP) begin
               long_hit    = 1'b1;
               long_done_d = 1'b1;
               rpt_cnt_d   = '0;
            end else begin
               long_cnt_d = long_cnt_q + LONG_W'(1);
            end
         end else if (REPEAT_EN) begin
            if (rpt_cnt_q == RPT_TOP) begin
               long_hit  = 1'b1;
               rpt_cnt_d = '0;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
         end
      end
      long_d = long_hit && !release_d;
   end

   // State registers; reset returns the channel to released with every count discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q      <= 2'b11;
         state_q     <= ~KEY_ACTIVE;
         cnt_q       <= '0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         long_cnt_q  <= '0;
         long_done_q <= 1'b0;
         rpt_cnt_q   <= '0;
      end else begin
         sync_q      <= {sync_q[0], key_i};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         long_cnt_q  <= long_cnt_d;
         long_done_q <= long_done_d;
         rpt_cnt_q   <= rpt_cnt_d;
      end
   end

   assign state_o   = state_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: KEY_W independent copies of the single-channel filter.
// Latency: as the channel filter; channels never interact.
// Backpressure: none; outputs are levels and single-cycle pulses.
module key_filter_multi
   import key_pkg::*;
#(
   parameter int unsigned KEY_W      = 4,
   parameter int unsigned CNT_MAX    = CNT_20MS,
   parameter int unsigned LONG_MAX   = LONG_1S,
   parameter bit          REPEAT_EN  = 1'b0,
   parameter int unsigned REPEAT_MAX = REPEAT_200MS
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_state,
   output logic [KEY_W-1:0] key_press_flag,
   output logic [KEY_W-1:0] key_release_flag,
   output logic [KEY_W-1:0] key_long_flag
);

   for (genvar g = 0; g < KEY_W; g++) begin : g_ch
      key_debounce_ch #(
         .CNT_MAX    (CNT_MAX),
         .LONG_MAX   (LONG_MAX),
         .REPEAT_EN  (REPEAT_EN),
         .REPEAT_MAX (REPEAT_MAX)
      ) u_ch (
         .clk_i     (sys_clk),
         .rst_ni    (sys_rst_n),
         .key_i     (key_in[g]),
         .state_o   (key_state[g]),
         .press_o   (key_press_flag[g]),
         .release_o (key_release_flag[g]),
         .long_o    (key_long_flag[g])
      );
   end

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: cycle-level behavioural model plus directed literal checks.
// Latency: key_in applied just after edge N gives flags at edge N+CNT_MAX+2.
// Backpressure: not applicable.
module tb_key_filter_multi;

   localparam int KW         = 4;
   localparam int CNT_MAX    = 24;
   localparam int LONG_MAX   = 100;
   localparam int REPEAT_MAX = 40;
   localparam bit REPEAT_EN  = 1'b1;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [KW-1:0] key_in;
   logic [KW-1:0] key_state, key_press_flag, key_release_flag, key_long_flag;

   key_filter_multi #(
      .KEY_W      (KW),
      .CNT_MAX    (CNT_MAX),
      .LONG_MAX   (LONG_MAX),
      .REPEAT_EN  (REPEAT_EN),
      .REPEAT_MAX (REPEAT_MAX)
   ) dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .key_in           (key_in),
      .key_state        (key_state),
      .key_press_flag   (key_press_flag),
      .key_release_flag (key_release_flag),
      .key_long_flag    (key_long_flag)
   );

   always #10 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [KW-1:0] in_at_edge = '1;
   bit            edge_valid = 1'b0;

   // Edge bookkeeping: what key_in the DUT saw at each rising edge, and whether it was out of reset.
   always @(posedge sys_clk) begin
      in_at_edge <= key_in;
      edge_valid <= sys_rst_n;
      cyc        <= cyc + 1;
   end

   // Behavioural model state.
   bit m_s1[KW], m_s2[KW], m_st[KW];
   int m_run[KW], m_age[KW];
   logic [KW-1:0] e_state, e_press, e_rel, e_long;

   // Observed event log, used by the literal checks.
   int press_cnt[KW], rel_cnt[KW], long_cnt[KW];
   int last_press[KW], last_rel[KW], first_long[KW], last_long[KW];
   int dur[KW];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < KW; c++) begin
         m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_st[c] = 1'b1;
         m_run[c] = 0; m_age[c] = 0;
      end
      e_state = '1; e_press = '0; e_rel = '0; e_long = '0;
   endtask

   // One rising edge: a level is accepted once the synchronised input has disagreed with the
   // debounced level for CNT_MAX straight cycles; long pulses fire at hold ages
   // LONG_MAX, LONG_MAX+REPEAT_MAX, ... measured in edges since the press edge.
   task automatic model_step(input logic [KW-1:0] v);
      for (int c = 0; c < KW; c++) begin
         bit sync_now;
         sync_now   = m_s2[c];
         e_press[c] = 1'b0;
         e_rel[c]   = 1'b0;
         e_long[c]  = 1'b0;
         if (sync_now != m_st[c]) begin
            m_run[c]++;
            if (m_run[c] == CNT_MAX) begin
               m_st[c]  = sync_now;
               m_run[c] = 0;
               if (sync_now == 1'b0) e_press[c] = 1'b1;
               else                  e_rel[c]   = 1'b1;
            end
         end else begin
            m_run[c] = 0;
         end
         m_s2[c] = m_s1[c];
         m_s1[c] = v[c];
         if (e_press[c]) begin
            m_age[c] = 0;
         end else if (m_st[c] == 1'b0) begin
            m_age[c]++;
            if (m_age[c] == LONG_MAX ||
                (REPEAT_EN && m_age[c] > LONG_MAX && (m_age[c] - LONG_MAX) % REPEAT_MAX == 0))
               e_long[c] = 1'b1;
         end
         e_state[c] = m_st[c];
      end
   endtask

   // Compare process: every falling edge, advance the model and check every output.
   initial begin
      model_reset();
      for (int c = 0; c < KW; c++) begin
         press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
         last_press[c] = -1; last_rel[c] = -1; first_long[c] = -1; last_long[c] = -1;
      end
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n)      model_reset();
         else if (edge_valid) model_step(in_at_edge);
         chk("key_state",        32'(key_state),        32'(e_state));
         chk("key_press_flag",   32'(key_press_flag),   32'(e_press));
         chk("key_release_flag", 32'(key_release_flag), 32'(e_rel));
         chk("key_long_flag",    32'(key_long_flag),    32'(e_long));
         for (int c = 0; c < KW; c++) begin
            if (key_press_flag[c] === 1'b1)   begin press_cnt[c]++; last_press[c] = cyc; end
            if (key_release_flag[c] === 1'b1) begin rel_cnt[c]++;   last_rel[c]   = cyc; end
            if (key_long_flag[c] === 1'b1) begin
               if (long_cnt[c] == 0) first_long[c] = cyc;
               long_cnt[c]++;
               last_long[c] = cyc;
            end
         end
      end
   end

   // Advance n cycles; stimulus always changes just after a falling edge.
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
      #2;
   endtask

   // Bounce key_in[1] for n cycles with runs capped at 10, ending on last_val.
   task automatic bounce1(input int n, input bit last_val);
      bit v;
      int run;
      v   = key_in[1];
      run = 0;
      for (int i = 0; i < n; i++) begin
         bit nv;
         if (i == n - 1)    nv = last_val;
         else if (run >= 10) nv = ~v;
         else               nv = bit'($urandom_range(0, 1));
         if (nv == v) run++;
         else         run = 1;
         v = nv;
         key_in[1] = nv;
         wait_cyc(1);
      end
   endtask

   // Directed scenarios followed by a long randomised run.
   initial begin
      int t, tr, pc;
      sys_rst_n = 1'b0;
      key_in    = '1;
      repeat (3) begin
         wait_cyc(1);
         key_in = 4'($urandom);
      end
      key_in = '1;
      wait_cyc(1);
      sys_rst_n = 1'b1;
      wait_cyc(5);
      chk("reset_state", 32'(key_state), 32'hF);
      chk("reset_no_flags", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                                + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);

      // Clean press on channel 0.
      t = cyc;
      key_in[0] = 1'b0;
      wait_cyc(27);
      chk("clean_press_edge",  32'(last_press[0]), 32'(t + 26));
      chk("clean_press_count", 32'(press_cnt[0]), 32'd1);
      chk("clean_press_state", 32'(key_state), 32'hE);
      key_in[0] = 1'b1;
      wait_cyc(30);

      // Bouncy press then bouncy release on channel 1.
      bounce1(31, 1'b1);
      t = cyc;
      key_in[1] = 1'b0;
      wait_cyc(50);
      bounce1(51, 1'b0);
      tr = cyc;
      key_in[1] = 1'b1;
      wait_cyc(30);
      chk("bounce_press_count", 32'(press_cnt[1]), 32'd1);
      chk("bounce_rel_count",   32'(rel_cnt[1]), 32'd1);
      chk("bounce_press_edge",  32'(last_press[1]), 32'(t + 26));
      chk("bounce_rel_edge",    32'(last_rel[1]), 32'(tr + 26));

      // Glitch one cycle short of acceptance on channel 2, then exactly long enough.
      key_in[2] = 1'b0;
      wait_cyc(23);
      key_in[2] = 1'b1;
      wait_cyc(30);
      chk("glitch_no_press", 32'(press_cnt[2]), 32'd0);
      chk("glitch_state",    32'(key_state[2]), 32'd1);
      t = cyc;
      key_in[2] = 1'b0;
      wait_cyc(24);
      key_in[2] = 1'b1;
      wait_cyc(30);
      chk("min_press_edge", 32'(last_press[2]), 32'(t + 26));
      chk("min_rel_edge",   32'(last_rel[2]), 32'(t + 50));

      // Long press with repeats on channel 3; release lands on a repeat terminal.
      t = cyc;
      key_in[3] = 1'b0;
      wait_cyc(300);
      key_in[3] = 1'b1;
      wait_cyc(40);
      chk("long_first_edge", 32'(first_long[3]), 32'(t + 126));
      chk("long_last_edge",  32'(last_long[3]), 32'(t + 286));
      chk("long_count",      32'(long_cnt[3]), 32'd5);
      chk("long_rel_edge",   32'(last_rel[3]), 32'(t + 326));

      // Two channels pressed together, then reset mid-count on a second press.
      t = cyc;
      key_in = key_in & 4'b1010;
      wait_cyc(30);
      chk("multi_press0", 32'(last_press[0]), 32'(t + 26));
      chk("multi_press2", 32'(last_press[2]), 32'(t + 26));
      key_in = '1;
      wait_cyc(30);
      t = cyc;
      key_in[0] = 1'b0;
      wait_cyc(22);
      pc = press_cnt[0];
      sys_rst_n = 1'b0;
      key_in    = '1;
      wait_cyc(1);
      sys_rst_n = 1'b1;
      wait_cyc(40);
      chk("reset_mid_no_press", 32'(press_cnt[0]), 32'(pc));
      chk("reset_mid_state",    32'(key_state), 32'hF);

      // Random holds and glitches on all channels against the model.
      for (int c = 0; c < KW; c++) dur[c] = int'($urandom_range(1, 40));
      repeat (3000) begin
         for (int c = 0; c < KW; c++) begin
            dur[c]--;
            if (dur[c] == 0) begin
               key_in[c] = ~key_in[c];
               if ($urandom_range(0, 3) == 0) dur[c] = int'($urandom_range(100, 250));
               else                           dur[c] = int'($urandom_range(1, 40));
            end
         end
         wait_cyc(1);
      end
      key_in = '1;
      wait_cyc(40);
      chk("final_state", 32'(key_state), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
- Parametrised multi-channel key debouncer; the successor to the single-key filter.
- Per channel: synchronises a raw active-low key, debounces it with a stability counter, and holds a debounced state.
- Emits one-cycle press and release flags, plus long-press and optional auto-repeat flags.
- Sits between the board key pins and the application control logic.

Parameters:
- KEY_W, 4, number of independent key channels (>=1).
- CNT_MAX, 20'd999_999, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >=2.
- LONG_MAX, 26'd49_999_999, cycles of debounced hold, counted from the press flag, before the first long flag (1 s); must be >=1.
- REPEAT_EN, 1'b0, 1 = keep pulsing the long flag every REPEAT_MAX cycles while held; 0 = single long flag.
- REPEAT_MAX, 24'd9_999_999, auto-repeat period in cycles (200 ms); must be >=1.

Ports:
- sys_clk, input, 1, system clock.
- sys_rst_n, input, 1, reset, asynchronous, active-low.
- key_in, input, KEY_W, raw key pins; asynchronous; 0 = pressed.
- key_state, output, KEY_W, debounced level per channel; 0 = pressed.
- key_press_flag, output, KEY_W, one-cycle pulse on an accepted 1->0 transition.
- key_release_flag, output, KEY_W, one-cycle pulse on an accepted 0->1 transition.
- key_long_flag, output, KEY_W, one-cycle pulse at the long-press threshold and on each repeat.

Behaviour:
- Reset state: sync registers = all 1; key_state = all 1; all flags = 0; all counters = 0.
  - Reset asserted mid-count discards the count; no flag is produced.
- Sync: 2-flop synchroniser per bit; key_sync lags key_in by 2 cycles. All further logic uses key_sync only.
- Debounce counter, per channel, width clog2(CNT_MAX):
  - Increments each cycle key_sync != key_state.
  - Clears to 0 on any cycle key_sync == key_state, so a single bounce restarts the count.
  - On the cycle cnt == CNT_MAX-1 with the mismatch still present: key_state takes key_sync at the next edge, cnt clears, and the matching press or release flag is high for exactly that one following cycle.
- Latency: a key_in change held stable yields flag and key_state update exactly CNT_MAX+2 clock edges after the key_in change is sampled.
- Press and release flags for one channel are never high together.
  - Each debounced transition yields exactly one flag.
  - No flag on a glitch shorter than CNT_MAX cycles.
- Long counter, per channel:
  - Runs only while key_state == 0.
  - Starts at 0 in the cycle key_press_flag is high; clears whenever key_state == 1.
  - At LONG_MAX-1: one-cycle key_long_flag.
  - REPEAT_EN = 0: the counter then holds; no further long flags until released and pressed again.
  - REPEAT_EN = 1: a repeat counter restarts at 0 and pulses key_long_flag at every REPEAT_MAX-1, until release.
- Simultaneous events:
  - If a long or repeat terminal count coincides with the cycle key_state returns to 1, the release flag fires and the long flag is suppressed.
  - Channels are fully independent; any combination of channels may flag in the same cycle.
- Counters saturate logically through the terminal compare; no wrap-around produces a spurious flag.

Decomposition:
- Shared package key_pkg:
  - KEY_ACTIVE = 1'b0, the pressed level.
  - Default timing constants: CNT_20MS, LONG_1S, REPEAT_200MS at 50 MHz.
  - A clog2-based width function for counter sizing.
- Sub-module key_debounce_ch: one channel holding the synchroniser, debounce counter, long/repeat counters and flag registers; same parameters minus KEY_W. Instantiated KEY_W times in a generate loop.
- Top level is wiring only.

Test Plan:
All scenarios use CNT_MAX=24, LONG_MAX=100, REPEAT_MAX=40, KEY_W=4, 50 MHz clock.
- Reset: sys_rst_n low for 20 ns -> key_state=4'hF; all flags 0; key_in activity during reset produces nothing.
- Clean press: key_in[0] 1->0 sampled at edge N, then held -> key_press_flag[0] high only at edge N+26; key_state[0]=0 from N+26; no other channel changes.
- Bouncy press: key_in[1] random for 31 cycles, then stable 0 for 50 cycles, then random for 51 cycles, then stable 1 -> exactly one press flag and one release flag, each 26 edges after the last toggle.
- Glitch: key_in[2] low for 23 cycles, then high -> no flag; key_state[2] stays 1.
- Long and repeat, REPEAT_EN=1: hold key_in[3] low for 300 cycles -> long flag 100 cycles after the press flag, then every 40 cycles. On release: release flag, no further long flags. Also force a release terminal coinciding with a repeat terminal -> release only.
- Multi-channel and reset: key_in[0] and key_in[2] pressed on the same edge -> both press flags in the same cycle. Assert sys_rst_n at count 20 of a second press -> no flag; all outputs back to reset values.
